// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC block family: controller states and width helpers.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Root width for a given radicand width.
  function automatic int unsigned out_width(input int unsigned in_w);
    return in_w / 2;
  endfunction

endpackage

// File: rtl/cordic_sqrt_step.sv
// One shift-subtract square-root iteration: consumes two radicand bits, emits one root bit.
module cordic_sqrt_step #(
  parameter int unsigned OUT_W = 16
) (
  input  logic [OUT_W:0]   rem_in,
  input  logic [OUT_W-1:0] root_in,
  input  logic [1:0]       bits,
  output logic [OUT_W:0]   rem_out,
  output logic             root_bit
);

  logic [OUT_W+2:0] acc;
  logic [OUT_W+2:0] trial;

  always_comb begin
    acc      = {rem_in, bits};
    trial    = {1'b0, root_in, 2'b01};
    root_bit = (acc >= trial);
    // A successful subtraction always fits in OUT_W+1 bits, so the low bits suffice.
    rem_out  = root_bit ? (acc[OUT_W:0] - trial[OUT_W:0]) : acc[OUT_W:0];
  end

endmodule

// File: rtl/cordic_sqrt_multi.sv
// Multi-channel iterative integer square root, one root bit per cycle, channels in order.
// Define CORDIC_SQRT_ROUND_EN for round-to-nearest roots; the default build gives floor roots.
module cordic_sqrt_multi
  import cordic_pkg::*;
#(
  parameter int unsigned IN_W = 32,
  parameter int unsigned N_CH = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_CH*IN_W-1:0]               in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [N_CH*out_width(IN_W)-1:0]    out_root,
  output logic [N_CH*(out_width(IN_W)+1)-1:0] out_rem,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam int unsigned OUT_W = out_width(IN_W);
  localparam int unsigned REM_W = OUT_W + 1;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned IT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(OUT_W - 1);

  state_e                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic [IT_W-1:0]         iter_q;
  logic [N_CH*IN_W-1:0]    data_q;
  logic [IN_W-1:0]         rad_q;
  logic [REM_W-1:0]        prem_q;
  logic [OUT_W-1:0]        proot_q;
  logic [N_CH*OUT_W-1:0]   out_root_q;
  logic [N_CH*REM_W-1:0]   out_rem_q;
  logic                    out_valid_q;
  logic                    in_ready_q;

  logic [REM_W-1:0]        step_rem;
  logic                    step_bit;
  logic [OUT_W-1:0]        root_nxt;
  logic [OUT_W-1:0]        root_fin;
  logic [CH_W-1:0]         ch_nxt;
  logic [IN_W-1:0]         rad_load;

  cordic_sqrt_step #(
    .OUT_W(OUT_W)
  ) u_step (
    .rem_in  (prem_q),
    .root_in (proot_q),
    .bits    (rad_q[IN_W-1 -: 2]),
    .rem_out (step_rem),
    .root_bit(step_bit)
  );

  assign root_nxt = {proot_q[OUT_W-2:0], step_bit};
  assign ch_nxt   = ch_q + 1'b1;
  assign rad_load = IN_W'(data_q >> (IN_W * ch_nxt));

`ifdef CORDIC_SQRT_ROUND_EN
  // Round up when the floor remainder exceeds the floor root; saturate at all-ones.
  always_comb begin
    root_fin = root_nxt;
    if ((step_rem > {1'b0, root_nxt}) && (root_nxt != {OUT_W{1'b1}})) begin
      root_fin = root_nxt + 1'b1;
    end
  end
`else
  assign root_fin = root_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      iter_q      <= '0;
      data_q      <= '0;
      rad_q       <= '0;
      prem_q      <= '0;
      proot_q     <= '0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            data_q     <= in_data;
            rad_q      <= in_data[IN_W-1:0];
            ch_q       <= '0;
            iter_q     <= '0;
            prem_q     <= '0;
            proot_q    <= '0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (iter_q == LAST_IT) begin
            out_root_q[ch_q*OUT_W +: OUT_W] <= root_fin;
            out_rem_q[ch_q*REM_W +: REM_W]  <= step_rem;
            iter_q  <= '0;
            prem_q  <= '0;
            proot_q <= '0;
            if (ch_q == LAST_CH) begin
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              // Next channel starts on the very next cycle, no bubble.
              ch_q  <= ch_nxt;
              rad_q <= rad_load;
            end
          end else begin
            iter_q  <= iter_q + 1'b1;
            prem_q  <= step_rem;
            proot_q <= root_nxt;
            rad_q   <= rad_q << 2;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_root  = out_root_q;
  assign out_rem   = out_rem_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_sqrt_multi.sv
// Bench for cordic_sqrt_multi (IN_W=32, N_CH=3); honours CORDIC_SQRT_ROUND_EN like the design.
module tb_cordic_sqrt_multi;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned N_CH  = 3;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned REM_W = 17;
  localparam int unsigned LAT   = N_CH * OUT_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_CH*IN_W-1:0]    in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_CH*OUT_W-1:0]   out_root;
  logic [N_CH*REM_W-1:0]   out_rem;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  typedef struct packed {
    logic [N_CH*OUT_W-1:0] root;
    logic [N_CH*REM_W-1:0] rem;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  cordic_sqrt_multi #(
    .IN_W(IN_W),
    .N_CH(N_CH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_root (out_root),
    .out_rem  (out_rem),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CH*IN_W-1:0] pk_in(input logic [31:0] a, b, c);
    return {c, b, a};
  endfunction

  function automatic logic [N_CH*OUT_W-1:0] pk_root(input logic [15:0] a, b, c);
    return {c, b, a};
  endfunction

  function automatic logic [N_CH*REM_W-1:0] pk_rem(input logic [16:0] a, b, c);
    return {c, b, a};
  endfunction

  // Reference: floating-point estimate corrected to the exact integer floor root.
  function automatic exp_t model(input logic [N_CH*IN_W-1:0] d);
    exp_t e;
    longint unsigned x, r, rm, q;
    e = '0;
    for (int c = 0; c < N_CH; c++) begin
      x = longint'(d[c*IN_W +: IN_W]);
      r = longint'($rtoi($sqrt(real'(x))));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      rm = x - r * r;
      q  = r;
`ifdef CORDIC_SQRT_ROUND_EN
      if (rm > r && r < 65535) q = r + 1;
`endif
      e.root[c*OUT_W +: OUT_W] = OUT_W'(q);
      e.rem[c*REM_W +: REM_W]  = REM_W'(rm);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [N_CH*IN_W-1:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_timeout", 1'(n < 100), 1'b1);
    tick();
    in_valid = 1'b0;
    sb.push_back(model(d));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, LAT);
  endtask

  task automatic drain(input bit rnd);
    exp_t e;
    for (int k = 0; k < 50; k++) begin
      out_ready = (!rnd || k == 49) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_ready) begin
        check("sb_nonempty", 1'(sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_root", out_root, e.root);
          check("sb_rem", out_rem, e.rem);
        end
        tick();
        out_ready = 1'b0;
        break;
      end
      tick();
    end
  endtask

  logic [N_CH*OUT_W-1:0] snap_root;
  logic [N_CH*REM_W-1:0] snap_rem;
  logic [N_CH*OUT_W-1:0] exp_b_root;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_root", out_root, 0);
    check("rst_rem", out_rem, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    tick();
    check("in_ready_after_edge", in_ready, 1);

    // Small radicands and the latency
    accept(pk_in(0, 1, 2));
    check("calc_in_ready", in_ready, 0);
    check("calc_busy", busy, 1);
    wait_valid("lat_small");
    check("small_root", out_root, pk_root(0, 1, 1));
    check("small_rem", out_rem, pk_rem(0, 0, 1));
    drain(1'b0);
    check("small_valid_drop", out_valid, 0);
    check("small_idle", busy, 0);

    // Rounding-sensitive values
`ifdef CORDIC_SQRT_ROUND_EN
    exp_b_root = pk_root(4, 4, 5);
`else
    exp_b_root = pk_root(4, 4, 4);
`endif
    accept(pk_in(16, 17, 24));
    wait_valid("lat_mid");
    check("mid_root", out_root, exp_b_root);
    check("mid_rem", out_rem, pk_rem(0, 1, 8));
    drain(1'b0);

    // Maximum radicand, rounding must saturate
    accept(pk_in(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    wait_valid("lat_max");
    check("max_root", out_root, pk_root(16'hFFFF, 16'hFFFF, 16'hFFFF));
    check("max_rem", out_rem, pk_rem(17'h1FFFE, 17'h1FFFE, 17'h1FFFE));
    drain(1'b0);

    // Back-pressure in DONE with an in_valid pulse that must be ignored
    accept(pk_in(1000, 65536, 12345));
    wait_valid("lat_stall");
    snap_root = out_root;
    snap_rem  = out_rem;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        in_data  = pk_in(4, 9, 16);
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      check("stall_root", out_root, snap_root);
      check("stall_rem", out_rem, snap_rem);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    drain(1'b0);
    check("release_valid", out_valid, 0);
    check("release_busy", busy, 0);
    check("release_in_ready", in_ready, 1);
    check("release_hold_root", out_root, snap_root);
    check("release_hold_rem", out_rem, snap_rem);

    // Reset in the middle of CALC
    accept(pk_in(7, 8, 9));
    repeat (20) tick();
    reset = 1'b1;
    #1;
    check("abort_root", out_root, 0);
    check("abort_rem", out_rem, 0);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
    check("abort_recover_ready", in_ready, 1);
    accept(pk_in(81, 100, 144));
    wait_valid("lat_after_abort");
    check("after_abort_root", out_root, pk_root(9, 10, 12));
    check("after_abort_rem", out_rem, pk_rem(0, 0, 0));
    drain(1'b0);

    // Random stream with random sink back-pressure
    for (int t = 0; t < 100; t++) begin
      logic [N_CH*IN_W-1:0] d;
      d = {$urandom(), $urandom(), $urandom()};
      if (t % 10 == 3) d[IN_W-1:0] = '0;
      if (t % 10 == 7) d[2*IN_W-1:IN_W] = '1;
      accept(d);
      wait_valid("lat_rand");
      drain(1'b1);
    end
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
